// File: rtl/instr_byte_packer.sv
// Packs one Y86-64 instruction into its byte image and streams it, one byte per
// accepted memory cycle, into byte-wide memory at an auto-incrementing pointer.
module instr_byte_packer #(
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [63:0]       in_valC,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              done,
  output logic              bad_icode
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              done_q, done_d;
  logic              bad_q, bad_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        len_q, len_d;
  logic [79:0]       image_q, image_d;
  logic [3:0]        in_len;
  logic [3:0]        idx_nxt;

  // Zero length marks an icode the processor does not implement.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd0;
    endcase
  endfunction

  // Byte k of the image sits at bits [8k+7:8k]; jXX/call (len 9) skip the register byte.
  function automatic logic [79:0] pack_image(
    input logic [3:0]  icode,
    input logic [3:0]  ifun,
    input logic [3:0]  ra,
    input logic [3:0]  rb,
    input logic [63:0] valc,
    input logic [3:0]  len
  );
    logic [79:0] img;
    img       = '0;
    img[7:0]  = {icode, ifun};
    case (len)
      4'd2:    img[15:8] = {ra, rb};
      4'd9:    img[71:8] = valc;
      4'd10: begin
        img[15:8]  = {ra, rb};
        img[79:16] = valc;
      end
      default: img[15:8] = 8'h00;
    endcase
    return img;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= BASE_RESET;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      bad_q       <= 1'b0;
      idx_q       <= '0;
      len_q       <= '0;
      image_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      bad_q       <= bad_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      image_q     <= image_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    done_d      = 1'b0;
    bad_d       = 1'b0;
    idx_d       = idx_q;
    len_d       = len_q;
    image_d     = image_q;
    in_len      = instr_len(in_icode);
    idx_nxt     = idx_q + 4'd1;
    case (state_q)
      IDLE: begin
        mem_we_d = 1'b0;
        if (base_load) wr_ptr_d = base_addr;
        if (in_valid) begin
          if (in_len != 4'd0) begin
            state_d     = EMIT;
            len_d       = in_len;
            idx_d       = 4'd0;
            image_d     = pack_image(in_icode, in_ifun, in_rA, in_rB, in_valC, in_len);
            mem_we_d    = 1'b1;
            // A base loaded in this same cycle already applies to this instruction.
            mem_addr_d  = base_load ? base_addr : wr_ptr_q;
            mem_wdata_d = {in_icode, in_ifun};
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (mem_ready) begin
          if (idx_nxt == len_q) begin
            state_d  = IDLE;
            wr_ptr_d = wr_ptr_q + ADDR_W'(len_q);
            mem_we_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            idx_d       = idx_nxt;
            mem_addr_d  = wr_ptr_q + ADDR_W'(idx_nxt);
            mem_wdata_d = 8'(image_q >> {idx_nxt, 3'b000});
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    wr_ptr    = wr_ptr_q;
    done      = done_q;
    bad_icode = bad_q;
  end

endmodule

// File: tb/tb_instr_byte_packer.sv
// Bench for instr_byte_packer: directed and randomized instructions against a
// byte-list reference model of the Y86-64 encoding.
module tb_instr_byte_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        base_load;
  logic [15:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
  logic [63:0] in_valC;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready;
  logic [15:0] wr_ptr;
  logic        done;
  logic        bad_icode;

  int checks   = 0;
  int failures = 0;

  logic [23:0] cap_q[$];
  int          done_cnt, bad_cnt, we_cnt;
  logic        prev_stall;
  logic [15:0] prev_addr;
  logic [7:0]  prev_data;
  logic [15:0] ptr_m;

  instr_byte_packer #(.ADDR_W(16), .BASE_RESET(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .base_load(base_load), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_rA(in_rA), .in_rB(in_rB), .in_valC(in_valC), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .wr_ptr(wr_ptr), .done(done), .bad_icode(bad_icode)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: records transfers and pulses mid-cycle, and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check({63'd0, mem_we}, 64'd1, "stall_we_held");
        check({48'd0, mem_addr}, {48'd0, prev_addr}, "stall_addr_held");
        check({56'd0, mem_wdata}, {56'd0, prev_data}, "stall_data_held");
      end
      if (mem_we) we_cnt++;
      if (mem_we && mem_ready) cap_q.push_back({mem_addr, mem_wdata});
      if (done) begin
        done_cnt++;
        check({63'd0, in_ready}, 64'd1, "ready_in_done_cycle");
      end
      if (bad_icode) bad_cnt++;
      prev_stall = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
    end
  end

  // Reference encoding built directly from the instruction-format rules.
  function automatic int ref_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 0;
    endcase
  endfunction

  task automatic ref_bytes(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [63:0] vc, output logic [7:0] q[$]);
    int n;
    q.delete();
    n = ref_len(ic);
    if (n > 0) q.push_back({ic, ifn});
    if (n == 2 || n == 10) q.push_back({ra, rb});
    if (n >= 9) for (int k = 0; k < 8; k++) q.push_back(vc[8*k +: 8]);
  endtask

  task automatic set_base(input logic [15:0] v);
    @(posedge clk); #1;
    base_load = 1'b1; base_addr = v;
    @(posedge clk); #1;
    base_load = 1'b0;
    check({48'd0, wr_ptr}, {48'd0, v}, "base_load_idle");
    ptr_m = v;
  endtask

  // mode: 0 = mem_ready always 1, 1 = random stalls, 2 = three stall cycles on byte index 3
  task automatic run_instr(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [63:0] vc, input int mode,
                           input bit poke, input bit ld, input logic [15:0] nb, input string tag);
    logic [7:0]  exp[$];
    logic [15:0] start;
    int          n, cyc, holds;
    ref_bytes(ic, ifn, ra, rb, vc, exp);
    n = exp.size();
    start = ld ? nb : ptr_m;
    cap_q.delete();
    done_cnt = 0; bad_cnt = 0; we_cnt = 0; holds = 0;
    @(posedge clk); #1;
    check({63'd0, in_ready}, 64'd1, {tag, "_ready"});
    in_valid = 1'b1; in_icode = ic; in_ifun = ifn; in_rA = ra; in_rB = rb; in_valC = vc;
    base_load = ld; base_addr = nb;
    @(posedge clk); #1;
    in_valid = 1'b0; base_load = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && bad_cnt == 0 && cyc < 200) begin
      if (poke && n > 0 && cyc == 0) begin
        base_load = 1'b1; base_addr = 16'h5A5A;
      end else begin
        base_load = 1'b0;
      end
      case (mode)
        1: mem_ready = ($urandom_range(0, 3) != 0);
        2: begin
          mem_ready = !(cap_q.size() == 3 && holds < 3);
          if (!mem_ready) holds++;
        end
        default: mem_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    base_load = 1'b0;
    mem_ready = 1'b1;
    check({63'd0, cyc < 200}, 64'd1, {tag, "_terminated"});
    if (mode == 0 && n > 0) check(cyc, n + 1, {tag, "_latency"});
    @(negedge clk); #1;
    check(cap_q.size(), n, {tag, "_nbytes"});
    for (int i = 0; i < n && i < cap_q.size(); i++) begin
      logic [15:0] a;
      a = start + 16'(i);
      check({48'd0, cap_q[i][23:8]}, {48'd0, a}, $sformatf("%s_addr%0d", tag, i));
      check({56'd0, cap_q[i][7:0]}, {56'd0, exp[i]}, $sformatf("%s_byte%0d", tag, i));
    end
    if (n > 0) begin
      check(done_cnt, 1, {tag, "_done_once"});
      check(bad_cnt, 0, {tag, "_no_bad"});
      if (mode == 2) check(we_cnt, n + 3, {tag, "_we_cycles"});
      else if (mode == 0) check(we_cnt, n, {tag, "_we_cycles"});
    end else begin
      check(bad_cnt, 1, {tag, "_bad_once"});
      check(done_cnt, 0, {tag, "_no_done"});
      check(we_cnt, 0, {tag, "_no_we"});
    end
    ptr_m = start + 16'(n);
    check({48'd0, wr_ptr}, {48'd0, ptr_m}, {tag, "_wr_ptr"});
    check({63'd0, in_ready}, 64'd1, {tag, "_ready_after"});
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; base_load = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_icode = '0; in_ifun = '0; in_rA = '0; in_rB = '0; in_valC = '0; mem_ready = 1'b1;
    ptr_m = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check({63'd0, mem_we}, 64'd0, "rst_mem_we");
    check({48'd0, mem_addr}, 64'd0, "rst_mem_addr");
    check({56'd0, mem_wdata}, 64'd0, "rst_mem_wdata");
    check({63'd0, done}, 64'd0, "rst_done");
    check({63'd0, bad_icode}, 64'd0, "rst_bad");
    check({48'd0, wr_ptr}, 64'd0, "rst_wr_ptr");
    check({63'd0, in_ready}, 64'd1, "rst_in_ready");
    rst_n = 1'b1;

    // irmovq at 0x100 with a base_load poke during EMIT
    set_base(16'h0100);
    run_instr(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 0, 1'b1, 1'b0, 16'h0, "irmovq");

    // jmp at 0 then halt; rA/rB must not appear
    set_base(16'h0000);
    run_instr(4'h7, 4'h0, 4'h5, 4'h6, 64'h40, 0, 1'b0, 1'b0, 16'h0, "jmp");
    run_instr(4'h0, 4'h0, 4'h7, 4'h8, 64'hFFFF, 0, 1'b0, 1'b0, 16'h0, "halt");

    // rmmovq with a three-cycle stall on byte 4
    run_instr(4'h4, 4'h0, 4'h1, 4'h2, 64'hDEADBEEFCAFEF00D, 2, 1'b0, 1'b0, 16'h0, "rmmovq_stall");

    // invalid icode
    run_instr(4'hC, 4'h0, 4'h1, 4'h2, 64'h1234, 0, 1'b0, 1'b0, 16'h0, "bad_c");

    // wrap across the top of memory
    set_base(16'hFFFF);
    run_instr(4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 0, 1'b0, 1'b0, 16'h0, "rrmovq_wrap");

    // base_load together with in_valid
    run_instr(4'h6, 4'h1, 4'h3, 4'h4, 64'h0, 0, 1'b0, 1'b1, 16'h2000, "opq_ldbase");

    // randomized instructions
    for (int t = 0; t < 24; t++) begin
      logic [15:0] nb;
      nb = ($urandom_range(0, 1) != 0) ? 16'(16'hFFF8 + 16'($urandom_range(0, 7))) : 16'($urandom);
      run_instr(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
                {32'($urandom), 32'($urandom)}, $urandom_range(0, 1),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), nb,
                $sformatf("rnd%0d", t));
    end

    // reset during byte 5 of irmovq
    cap_q.delete();
    @(posedge clk); #1;
    in_valid = 1'b1; in_icode = 4'h3; in_ifun = 4'h0; in_rA = 4'hF; in_rB = 4'h1;
    in_valC = 64'h1122334455667788;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (cap_q.size() < 4 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({63'd0, mem_we}, 64'd1, "midrst_we_before");
    rst_n = 1'b0;
    #1;
    check({63'd0, mem_we}, 64'd0, "midrst_we");
    check({48'd0, wr_ptr}, 64'd0, "midrst_wr_ptr");
    check({63'd0, in_ready}, 64'd1, "midrst_idle");
    @(posedge clk); #1;
    rst_n = 1'b1;
    ptr_m = 16'h0000;
    run_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 0, 1'b0, 1'b0, 16'h0, "nop_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
